// File: rtl/pipeline_stage_buffer.sv
// Elastic DEPTH-entry pipeline register with valid/ready handshakes, synchronous flush and occupancy count.
// Optional combinational bypass when empty is enabled by defining PIPELINE_STAGE_BYPASS_EN.
module pipeline_stage_buffer #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2,
  parameter int CNTW  = $clog2(DEPTH + 1)
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CNTW-1:0]  count,
  output logic             full,
  output logic             empty
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW-1:0]   LAST_PTR = PW'(DEPTH - 1);
  localparam logic [CNTW-1:0] DEPTH_C  = CNTW'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wrPtr_q, wrPtr_d;
  logic [PW-1:0]    rdPtr_q, rdPtr_d;
  logic [CNTW-1:0]  count_q, count_d;
  logic             push, pop, bypass, doWrite, doRead;

  // Pointers wrap explicitly so non-power-of-two depths work.
  function automatic logic [PW-1:0] nextPtr(input logic [PW-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PW'(1);
  endfunction

  assign full     = (count_q == DEPTH_C);
  assign empty    = (count_q == '0);
  assign count    = count_q;
  assign in_ready = !full && !RST;
  assign push     = in_valid && in_ready;
  assign pop      = out_valid && out_ready;

`ifdef PIPELINE_STAGE_BYPASS_EN
  assign bypass = empty && !flush && !RST;
`else
  assign bypass = 1'b0;
`endif

  always_comb begin
    out_valid = !empty;
    out_data  = empty ? '0 : mem_q[rdPtr_q];
    if (bypass) begin
      out_valid = in_valid;
      out_data  = in_data;
    end
  end

  // A payload consumed straight through the bypass is never written.
  assign doWrite = push && !(bypass && out_ready);
  assign doRead  = pop && !empty;

  always_comb begin
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    count_d = count_q;
    if (flush) begin
      wrPtr_d = '0;
      rdPtr_d = '0;
      count_d = '0;
    end else begin
      if (doWrite) wrPtr_d = nextPtr(wrPtr_q);
      if (doRead)  rdPtr_d = nextPtr(rdPtr_q);
      if (doWrite && !doRead)      count_d = count_q + CNTW'(1);
      else if (doRead && !doWrite) count_d = count_q - CNTW'(1);
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
      count_q <= count_d;
      if (doWrite && !flush) mem_q[wrPtr_q] <= in_data;
    end
  end

`ifndef SYNTHESIS
  countBound: assert property (@(posedge CLK) disable iff (RST) count_q <= DEPTH_C);
`endif

endmodule

// File: doc/pipeline_stage_buffer.md
Name: pipeline_stage_buffer

Overview:
- Parametrised elastic pipeline register for the pipelined datapath. It generalises the fixed single-cycle latch between stages into a DEPTH-entry, WIDTH-bit buffer.
- Uses a valid/ready handshake in both directions, a synchronous flush for branch/jump squash, and an occupancy count for the hazard unit.
- One instance sits between each pair of stages (IF/ID, ID/EX, EX/MEM, MEM/WB). The payload is the packed stage-register struct.

Parameters:
- WIDTH, 32, payload bits per entry (the packed stage struct width); must be >= 1.
- DEPTH, 2, number of entries; must be >= 1; any value, not only powers of 2.
- CNTW, $clog2(DEPTH+1), width of the occupancy count.

Ports:
- CLK  input  1  clock; all state updates on the posedge.
- RST  input  1  reset; synchronous, active-high.
- flush  input  1  squash all held entries (branch/jump taken, halt drain).
- in_valid  input  1  upstream stage presents a valid payload.
- in_ready  output  1  buffer accepts a payload this cycle.
- in_data  input  WIDTH  upstream payload.
- out_valid  output  1  head entry valid.
- out_ready  input  1  downstream stage consumes the head this cycle.
- out_data  output  WIDTH  head payload.
- count  output  CNTW  number of held entries, 0..DEPTH.
- full  output  1  count == DEPTH.
- empty  output  1  count == 0.

Behaviour:
- Storage is a circular array mem[DEPTH] with a write pointer wr_ptr, a read pointer rd_ptr and the register count.
- Pointer width is max(1, $clog2(DEPTH)). A pointer wraps from DEPTH-1 to 0 explicitly; wrap is not natural overflow.
- push = in_valid && in_ready. pop = out_valid && out_ready.
- in_ready = !full && !RST. It is combinational from registered state and does not depend on out_ready: no pass-through when full.
- out_valid = !empty. out_data = mem[rd_ptr] when !empty, and all zeros when empty, so checking is deterministic.
- Latency: data pushed at edge N is visible on out_data/out_valid after edge N (1 cycle).
- push only: write mem[wr_ptr], advance wr_ptr, count+1.
- pop only: advance rd_ptr, count-1.
- push and pop in the same cycle (legal only when !full):
  - write, advance both pointers, count unchanged;
  - with DEPTH==1 this cannot occur, because in_ready is 0 while the single entry is held.
- flush:
  - At the next edge, count=0 and wr_ptr=rd_ptr=0; mem contents are don't-care.
  - flush has priority over push and pop in the same cycle: the push is dropped and the pop is still seen by downstream that cycle but has no effect.
  - in_ready and out_valid are not gated by flush combinationally.
- Reset:
  - While RST is high at an edge: count=0, pointers=0, mem cleared to 0.
  - Outputs during/after reset: out_valid=0, out_data=0, empty=1, full=0, count=0.
  - in_ready=0 while RST is asserted and 1 from the first cycle RST is low.
  - Reset mid-operation discards all entries identically to flush.
- Ordering: strict FIFO; no entry is duplicated or lost except by flush/reset.
- Assertions (simulation only):
  - in_data is stable while in_valid && !in_ready is upstream's obligation; it is not checked here.
  - count never exceeds DEPTH.

Optional Feature:
- Macro PIPELINE_STAGE_BYPASS_EN.
- Defined: when empty && !flush, out_valid=in_valid and out_data=in_data combinationally.
  - If out_ready is also high, the payload passes straight through: no write, no pointer or count change.
  - If out_ready is low, the payload is stored as normal.
  - in_ready is unchanged.
  - Latency is 0 cycles when empty.
- Undefined: no combinational path from in_* to out_*. Latency is always 1 cycle, as specified above.

Test Plan:
- Reset: assert RST 2 cycles with in_valid=1, in_data=32'hDEADBEEF -> count=0, out_valid=0, out_data=0, in_ready=0 during RST and 1 after; nothing stored.
- Fill/drain (DEPTH=2): push 32'h11, 32'h22 with out_ready=0 -> full=1, in_ready=0. A third push of 32'h33 is held off. Set out_ready=1 -> outputs 32'h11 then 32'h22, count 2→1→0.
- Wrap (DEPTH=3): stream 10 values 1..10 with out_ready toggling 1,0,1,0… -> output sequence exactly 1..10, count never >3, pointers wrap with no corruption.
- Simultaneous push/pop at count=1 (DEPTH=2): push 32'hA5 while popping the head -> head popped, count stays 1, next out_data=32'hA5.
- Flush priority: count=2, flush=1 together with in_valid=1, in_data=32'h77 -> next cycle count=0, out_valid=0; 32'h77 never appears on out_data.
- Bypass (macro defined, DEPTH=1): empty, in_valid=1, in_data=32'h5A, out_ready=1 -> same-cycle out_valid=1, out_data=32'h5A, count stays 0. With the macro undefined, 32'h5A appears one cycle later.
